// File: rtl/keypad_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl_if
// Brief    : Keypad-side and key-output signals of the keypad scan controller.
//            The master modport is the scan controller; the slave modport is
//            the keypad matrix plus the password-check consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_ctrl_if;
   logic [3:0] col_n;       // keypad columns, active-low, asynchronous
   logic [3:0] row_n;       // keypad row drives, active-low
   logic [3:0] key_code;    // {row[1:0], col[1:0]} of the last accepted key
   logic       key_valid;   // one-clk pulse, key_code valid in same cycle
   logic       key_held;    // accepted key is still pressed

   modport master (
      input  col_n,
      output row_n,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output col_n,
      input  row_n,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Brief    : 4x4 matrix keypad scanner. Builds a scan-rate tick enable from
//            clk, walks the active-low row drives, synchronises and debounces
//            the column returns and emits one key code per accepted press.
// Options  : KEY_REPEAT_EN - when defined, key_valid pulses again every
//            REPEAT_TICKS ticks while the accepted key stays pressed.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
   parameter int CLK_FREQ     = 50000000,
   parameter int SCAN_FREQ    = 1000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_TICKS = 500
) (
   input  wire logic          clk,
   input  wire logic          n_rst,
   keypad_scan_ctrl_if.master kp
);
   localparam int c_tick_div = CLK_FREQ / SCAN_FREQ;
   localparam int c_pre_w    = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;
   localparam int c_cnt_w    = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_tick_div - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_done = c_cnt_w'(DEBOUNCE_CNT);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   // Reject configurations that cannot produce a tick or a debounce window
   generate
      if (c_tick_div < 1 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_bad_params
         $error("keypad_scan_ctrl: tick divider, DEBOUNCE_CNT and REPEAT_TICKS must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCAN     = 2'd1,
      ST_DEBOUNCE = 2'd2,
      ST_PRESSED  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [c_pre_w-1:0]   presc_q, presc_d;
   logic [3:0]           col_meta_q, col_meta_d;
   logic [3:0]           col_sync_q, col_sync_d;
   logic [1:0]           row_q, row_d;
   logic [3:0]           cand_q, cand_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;       // press debounce, then release debounce
   logic [3:0]           row_n_q, row_n_d;
   logic [3:0]           key_code_q, key_code_d;
   logic                 key_valid_q, key_valid_d;
   logic                 key_held_q, key_held_d;

   logic                 tick;
   logic                 any_low;
   logic                 hit;
   logic [1:0]           hit_col;
   logic                 accept;

`ifdef KEY_REPEAT_EN
   localparam int c_rep_w = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_TICKS - 1);
   logic [c_rep_w-1:0]   rep_q, rep_d;
`else
   // Without auto-repeat there is no repeat counter at all
`endif

   // Free-running scan-rate divider and two-stage column synchroniser
   always_comb begin
      tick       = (presc_q == c_pre_last);
      presc_d    = tick ? '0 : presc_q + 1'b1;
      col_meta_d = kp.col_n;
      col_sync_d = col_meta_q;
   end

   // Column decode: exactly one low column is a hit, two or more is a ghost
   always_comb begin
      any_low = ~&col_sync_q;
      hit     = 1'b0;
      hit_col = 2'd0;
      case (col_sync_q)
         4'b1110: begin hit = 1'b1; hit_col = 2'd0; end
         4'b1101: begin hit = 1'b1; hit_col = 2'd1; end
         4'b1011: begin hit = 1'b1; hit_col = 2'd2; end
         4'b0111: begin hit = 1'b1; hit_col = 2'd3; end
         default: begin hit = 1'b0; hit_col = 2'd0; end
      endcase
   end

   // Scan/debounce FSM next state and outputs; decisions only on tick
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      accept      = 1'b0;

      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (any_low) begin
                  state_d = ST_SCAN;
                  row_d   = 2'd0;
               end
            end
            ST_SCAN: begin
               if (hit) begin
                  cand_d = {row_q, hit_col};
                  cnt_d  = c_cnt_one;
                  if (c_cnt_done == c_cnt_one) begin
                     accept = 1'b1;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end else if (row_q == 2'd3) begin
                  state_d = ST_IDLE;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (hit && ({row_q, hit_col} == cand_q)) begin
                  if (cnt_q + 1'b1 == c_cnt_done) begin
                     accept = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = ST_SCAN;
                  row_d   = 2'd0;
                  cnt_d   = '0;
               end
            end
            ST_PRESSED: begin
               // Row stays on the accepted key's row, so only that row's
               // columns can hold off the release count
               if (any_low) begin
                  cnt_d = '0;
               end else if (cnt_q + 1'b1 == c_cnt_done) begin
                  cnt_d      = '0;
                  key_held_d = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (accept) begin
         key_code_d  = cand_d;
         key_valid_d = 1'b1;
         key_held_d  = 1'b1;
         cnt_d       = '0;
         state_d     = ST_PRESSED;
      end

`ifdef KEY_REPEAT_EN
      rep_d = rep_q;
      if (accept || state_d == ST_IDLE) begin
         rep_d = '0;
      end else if (tick && state_q == ST_PRESSED && state_d == ST_PRESSED) begin
         if (rep_q == c_rep_last) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
`else
      // One key_valid per press; nothing to count while the key is held
`endif

      row_n_d = (state_d == ST_IDLE) ? 4'b0000 : ~(4'b0001 << row_d);
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         col_meta_q  <= 4'hF;
         col_sync_q  <= 4'hF;
         row_q       <= 2'd0;
         cand_q      <= 4'h0;
         cnt_q       <= '0;
         row_n_q     <= 4'b0000;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         col_meta_q  <= col_meta_d;
         col_sync_q  <= col_sync_d;
         row_q       <= row_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         row_n_q     <= row_n_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign kp.row_n     = row_n_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Brief    : Self-checking bench for keypad_scan_ctrl. A row_n-driven keypad
//            matrix model produces col_n; expectations (key codes, pulse
//            counts, latency windows, release timing) come from the keypad
//            rules computed directly in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;
   localparam int CLK_FREQ     = 1000;
   localparam int SCAN_FREQ    = 100;
   localparam int DEBOUNCE_CNT = 4;
   localparam int REPEAT_TICKS = 20;
   localparam int TICK_CLKS    = CLK_FREQ / SCAN_FREQ;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [15:0] keys;        // bit r*4+c set = key at row r, column c pressed
   logic [3:0]  col_model;

   int          n_checks = 0;
   int          n_pass   = 0;

   int          vcnt       = 0;   // key_valid pulses seen
   int          dbl        = 0;   // key_valid high on two consecutive clks
   logic [3:0]  last_code  = 4'h0;
   logic        prev_valid = 1'b0;

   keypad_scan_ctrl_if kp_if ();

   keypad_scan_ctrl #(
      .CLK_FREQ     (CLK_FREQ),
      .SCAN_FREQ    (SCAN_FREQ),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .kp    (kp_if)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low when its row is driven
   always_comb begin
      col_model = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !kp_if.row_n[r]) col_model[c] = 1'b0;
         end
      end
   end
   assign kp_if.col_n = col_model;

   // Pulse monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (kp_if.key_valid) begin
         vcnt      <= vcnt + 1;
         last_code <= kp_if.key_code;
         if (prev_valid) dbl <= dbl + 1;
      end
      prev_valid <= kp_if.key_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One press: optional bounce, stable press, hold, optional same-row
   // second key, release; hold is counted in ticks from the accept pulse
   task automatic do_press(input int r, input int c, input int nb, input int hold, input bit second);
      int         code;
      int         v0;
      int         n;
      int         lo;
      int         hi;
      int         spent;
      int         exp_pulses;
      bit         seen;
      logic [3:0] exp_row;
      code    = r * 4 + c;
      exp_row = ~(4'b0001 << r);
      v0      = vcnt;
      for (int i = 0; i < nb; i++) begin
         keys = (i % 2 == 0) ? (16'h0001 << code) : 16'h0000;
         step(TICK_CLKS);
      end
      check($sformatf("no_pulse_during_bounce key=%0h", code), vcnt - v0, 0);

      keys = 16'h0001 << code;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < (r + DEBOUNCE_CNT + 7) * TICK_CLKS + 13) begin
         step(1);
         n++;
         if (vcnt != v0) seen = 1'b1;
      end
      check($sformatf("accept_seen key=%0h", code), 32'(seen), 1);
      if (nb == 0) begin
         lo = (r + DEBOUNCE_CNT) * TICK_CLKS + 4;
         hi = lo + TICK_CLKS - 1;
         check($sformatf("accept_latency key=%0h clks=%0d window=%0d..%0d", code, n, lo, hi),
               32'(n >= lo && n <= hi), 1);
      end
      check($sformatf("key_code key=%0h", code), 32'(last_code), code);
      check($sformatf("key_held_on key=%0h", code), 32'(kp_if.key_held), 1);
      check($sformatf("row_n_held key=%0h", code), 32'(kp_if.row_n), 32'(exp_row));

      spent = 0;
      if (second) begin
         keys  = keys | (16'h0001 << (r * 4 + (c + 1) % 4));
         step(3 * TICK_CLKS);
         spent = 3;
         keys  = 16'h0001 << code;
      end
      step((hold - spent) * TICK_CLKS);
`ifdef KEY_REPEAT_EN
      exp_pulses = 1 + hold / REPEAT_TICKS;
`else
      exp_pulses = 1;
`endif
      check($sformatf("pulses_while_held key=%0h hold=%0d", code, hold), vcnt - v0, exp_pulses);
      check($sformatf("held_still key=%0h", code), 32'(kp_if.key_held), 1);
      check($sformatf("row_n_still key=%0h", code), 32'(kp_if.row_n), 32'(exp_row));

      keys = 16'h0000;
      step(2 * TICK_CLKS);
      check($sformatf("held_during_release key=%0h", code), 32'(kp_if.key_held), 1);
      n = 0;
      while (kp_if.key_held && n < 4 * TICK_CLKS) begin
         step(1);
         n++;
      end
      check($sformatf("released key=%0h", code), 32'(kp_if.key_held), 0);
      check($sformatf("code_kept key=%0h", code), 32'(kp_if.key_code), code);
      check($sformatf("pulses_total key=%0h", code), vcnt - v0, exp_pulses);
      step(5 * TICK_CLKS);
      check($sformatf("row_n_idle key=%0h", code), 32'(kp_if.row_n), 0);
   endtask

   // Two keys in one row: never a valid hit, scanning keeps cycling
   task automatic do_ghost(input int r, input int c0, input int c1, input int ticks);
      int v0;
      bit saw_r3;
      bit saw_idle;
      v0       = vcnt;
      saw_r3   = 1'b0;
      saw_idle = 1'b0;
      keys     = (16'h0001 << (r * 4 + c0)) | (16'h0001 << (r * 4 + c1));
      for (int i = 0; i < ticks * TICK_CLKS; i++) begin
         step(1);
         if (kp_if.row_n == 4'b0111) saw_r3 = 1'b1;
         if (kp_if.row_n == 4'b0000) saw_idle = 1'b1;
      end
      check($sformatf("ghost_no_pulse r=%0d c=%0d,%0d", r, c0, c1), vcnt - v0, 0);
      check($sformatf("ghost_not_held r=%0d", r), 32'(kp_if.key_held), 0);
      check($sformatf("ghost_scan_cycles r=%0d", r), 32'(saw_r3 && saw_idle), 1);
      keys = 16'h0000;
      step(6 * TICK_CLKS);
   endtask

   initial begin
      int r;
      int c;
      int c1;
      int v0;
      int n;
      keys  = 16'h0000;
      n_rst = 1'b0;
      step(3);
      check("rst_row_n", 32'(kp_if.row_n), 0);
      check("rst_key_code", 32'(kp_if.key_code), 0);
      check("rst_key_valid", 32'(kp_if.key_valid), 0);
      check("rst_key_held", 32'(kp_if.key_held), 0);
      n_rst = 1'b1;
      step(2 * TICK_CLKS);

      do_press(2, 1, 0, 8, 1'b0);
      do_press(2, 1, 2, 6, 1'b1);
      do_ghost(1, 0, 3, 20);
      do_press(3, 3, 0, 7, 1'b0);
      do_press(1, 1, 0, 65, 1'b0);

      for (int k = 0; k < 6; k++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         do_press(r, c, 2 * $urandom_range(0, 2), $urandom_range(5, 12), 1'($urandom_range(0, 1)));
         if (k % 2 == 1) begin
            c1 = (c + 1 + $urandom_range(0, 2)) % 4;
            do_ghost(r, c, c1, $urandom_range(8, 15));
         end
      end

      // Reset in the middle of debouncing key row0/col0
      keys = 16'h0001;
      n    = 0;
      while (kp_if.row_n != 4'b1110 && n < 3 * TICK_CLKS) begin
         step(1);
         n++;
      end
      check("scan_started_before_reset", 32'(kp_if.row_n), 32'(4'b1110));
      step(2 * TICK_CLKS + 5);
      v0    = vcnt;
      n_rst = 1'b0;
      #1;
      check("async_rst_row_n", 32'(kp_if.row_n), 0);
      check("async_rst_key_code", 32'(kp_if.key_code), 0);
      check("async_rst_key_valid", 32'(kp_if.key_valid), 0);
      check("async_rst_key_held", 32'(kp_if.key_held), 0);
      keys = 16'h0000;
      step(2 * TICK_CLKS);
      n_rst = 1'b1;
      step(10 * TICK_CLKS);
      check("no_pulse_after_reset", vcnt - v0, 0);
      check("idle_after_reset_held", 32'(kp_if.key_held), 0);
      check("idle_after_reset_row_n", 32'(kp_if.row_n), 0);

      check("no_back_to_back_valid", dbl, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
